// File: rtl/console_uart_tx.sv
// console_uart_tx: CONSOLE_OUT byte FIFO feeding an asynchronous UART transmitter (8N1).
// Define CONSOLE_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module console_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] CONSOLE_OUT,
  input  logic       CONSOLE_OUT_valid,
  output logic       CONSOLE_OUT_ready,
  output logic       TX,
  output logic       TX_busy,
  output logic [2:0] state_dbg
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef CONSOLE_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [BAUD_W-1:0]  baud, baud_next;
  logic [2:0]         bit_idx, bit_next;
  logic [7:0]         shift, shift_next;
  logic               tx_next;
  logic               push, pop, fifo_empty, baud_end;
`ifdef CONSOLE_TX_PARITY_EN
  logic               par_bit, par_next;
`endif

  // Handshake: a byte transfers on a rising CLK edge where CONSOLE_OUT_valid && CONSOLE_OUT_ready;
  // ready depends only on the registered count, and a stalled producer simply holds its byte.
  assign CONSOLE_OUT_ready = (count != CNT_FULL);
  assign push       = CONSOLE_OUT_valid && CONSOLE_OUT_ready;
  assign fifo_empty = (count == '0);
  assign baud_end   = (baud == BAUD_LAST);
  assign TX_busy    = (state != IDLE) || !fifo_empty;
  assign state_dbg  = state;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= CONSOLE_OUT;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TX      <= 1'b1;
`ifdef CONSOLE_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      TX      <= tx_next;
`ifdef CONSOLE_TX_PARITY_EN
      par_bit <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
`ifdef CONSOLE_TX_PARITY_EN
    par_next   = par_bit;
`endif
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
`ifdef CONSOLE_TX_PARITY_EN
          par_next   = ^mem[rd_ptr];
`endif
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next  = '0;
          shift_next = shift >> 1;
          if (bit_idx == 3'd7) begin
`ifdef CONSOLE_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
`ifdef CONSOLE_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_next  = '0;
          state_next = STOP;
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
`ifdef CONSOLE_TX_PARITY_EN
            par_next   = ^mem[rd_ptr];
`endif
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
      end
    endcase
  end

  // TX is registered from the next-state view, so the line changes on the same edge as the state.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef CONSOLE_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

endmodule
